// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    localparam int BOOT_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } boot_state_e;

    function automatic int boot_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/boot_csum.sv
// Wrapping 32-bit sum of accepted boot words, used when IMEM_BOOT_LOADER_CHECKSUM_EN is defined.
module boot_csum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       sum
);

    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sum_q <= '0;
        end else if (add_en) begin
            sum_q <= sum_q + 32'(data);
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory and sequences the CPU reset release.
// Optional checksum verification is enabled with `define IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = BOOT_DATA_W,
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    input  logic [31:0]       exp_sum,
`endif
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(boot_depth(ADDR_W));
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    boot_state_e       state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpuRstN_q, busy_q, done_q, err_q;
    logic              startTake, transfer, lastSumOk, zeroSumOk;

    assign startTake = start && (state_q == IDLE || state_q == RUN || state_q == ERR);
    assign transfer  = s_valid && (state_q == LOAD);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] expSum_q, csumSum;

    boot_csum #(.DATA_W(DATA_W)) u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (startTake),
        .add_en (transfer),
        .data   (s_data),
        .sum    (csumSum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            expSum_q <= '0;
        end else if (startTake) begin
            expSum_q <= exp_sum;
        end
    end

    // The last word is not yet in the accumulator, so fold it in here.
    assign lastSumOk = (csumSum + 32'(s_data)) == expSum_q;
    assign zeroSumOk = (exp_sum == 32'd0);
`else
    assign lastSumOk = 1'b1;
    assign zeroSumOk = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        holdCnt_d = holdCnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (startTake) begin
            len_d     = prog_len;
            count_d   = '0;
            holdCnt_d = '0;
            if (prog_len == '0) begin
                state_d = zeroSumOk ? HOLD : ERR;
            end else if (prog_len > DEPTH) begin
                state_d = ERR;
            end else begin
                state_d = LOAD;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (transfer) begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = s_data;
                        count_d = count_q + 1'b1;
                        if (count_q == len_q - 1'b1) begin
                            state_d   = lastSumOk ? HOLD : ERR;
                            holdCnt_d = '0;
                        end
                    end
                end
                HOLD: begin
                    if (holdCnt_q == HOLD_LAST) begin
                        state_d = RUN;
                    end else begin
                        holdCnt_d = holdCnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            count_q   <= '0;
            holdCnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpuRstN_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            holdCnt_q <= holdCnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpuRstN_q <= (state_d == RUN);
            busy_q    <= (state_d == LOAD) || (state_d == HOLD);
            done_q    <= (state_d == RUN);
            err_q     <= (state_d == ERR);
        end
    end

    assign s_ready    = (state_q == LOAD);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst_n  = cpuRstN_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (checksum steps under IMEM_BOOT_LOADER_CHECKSUM_EN).
module tb_imem_boot_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [10:0] prog_len;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] exp_sum;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};

    imem_boot_loader #(.ADDR_W(10), .DATA_W(32), .RESET_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .prog_len   (prog_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        .exp_sum    (exp_sum),
`endif
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 ns after the capturing edge.
    task automatic applyStimulus(input logic st, input logic [10:0] len,
                                 input logic v, input logic [31:0] d);
        start    = st;
        prog_len = len;
        s_valid  = v;
        s_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " s_ready"},    32'(s_ready),    32'd0);
        checkOutput({tag, " imem_we"},    32'(imem_we),    32'd0);
        checkOutput({tag, " imem_addr"},  32'(imem_addr),  32'd0);
        checkOutput({tag, " imem_wdata"}, imem_wdata,      32'd0);
        checkOutput({tag, " cpu_rst_n"},  32'(cpu_rst_n),  32'd0);
        checkOutput({tag, " busy"},       32'(busy),       32'd0);
        checkOutput({tag, " done"},       32'(done),       32'd0);
        checkOutput({tag, " err"},        32'(err),        32'd0);
    endtask

    // Four post-accept edges with the given s_valid: release lands exactly on the fourth.
    task automatic holdPhase(input string tag, input logic v);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 11'd0, v, 32'hFFFF_FFFF);
            checkOutput({tag, " hold imem_we"}, 32'(imem_we), 32'd0);
            checkOutput({tag, " hold cpu_rst_n"}, 32'(cpu_rst_n), (k == 4) ? 32'd1 : 32'd0);
        end
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int    nWrites;
        int    nextAddr;
        logic  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        exp_sum = 32'd0;
`endif
        rst_n = 1'b0;
        applyStimulus(1'b0, 11'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 11'd0, 1'b0, 32'd0);
        checkResetValues("reset");
        rst_n = 1'b1;

        $display("[TB] four-word load, s_valid held high");
        applyStimulus(1'b1, 11'd4, 1'b1, prog[0]);
        checkOutput("t1 s_ready", 32'(s_ready), 32'd1);
        checkOutput("t1 busy", 32'(busy), 32'd1);
        checkOutput("t1 no early write", 32'(imem_we), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 11'd0, 1'b1, prog[i]);
            checkOutput("t1 imem_we", 32'(imem_we), 32'd1);
            checkOutput("t1 imem_addr", 32'(imem_addr), 32'(i));
            checkOutput("t1 imem_wdata", imem_wdata, prog[i]);
        end
        checkOutput("t1 s_ready after last", 32'(s_ready), 32'd0);
        holdPhase("t1", 1'b0);

        $display("[TB] restart from RUN with two words");
        applyStimulus(1'b1, 11'd2, 1'b0, 32'd0);
        checkOutput("t5 cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("t5 busy", 32'(busy), 32'd1);
        checkOutput("t5 done", 32'(done), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 11'd0, 1'b1, 32'hCAFE_0000 + 32'(i));
            checkOutput("t5 imem_we", 32'(imem_we), 32'd1);
            checkOutput("t5 imem_addr", 32'(imem_addr), 32'(i));
            checkOutput("t5 imem_wdata", imem_wdata, 32'hCAFE_0000 + 32'(i));
        end
        holdPhase("t5", 1'b0);

        $display("[TB] three words with valid gaps");
        applyStimulus(1'b1, 11'd3, 1'b0, 32'd0);
        nWrites = 0;
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b0, 11'd0, pat[j], 32'hA0 + 32'(j));
            checkOutput("t2 imem_we", 32'(imem_we), 32'(pat[j]));
            if (pat[j]) begin
                checkOutput("t2 imem_addr", 32'(imem_addr), 32'(nWrites));
                checkOutput("t2 imem_wdata", imem_wdata, 32'hA0 + 32'(j));
                nWrites++;
            end
        end
        checkOutput("t2 write count", 32'(nWrites), 32'd3);
        holdPhase("t2", 1'b0);

        $display("[TB] zero length then oversize length");
        applyStimulus(1'b1, 11'd0, 1'b0, 32'd0);
        checkOutput("t3 zero busy", 32'(busy), 32'd1);
        checkOutput("t3 zero cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("t3 zero imem_we", 32'(imem_we), 32'd0);
        holdPhase("t3 zero", 1'b1);
        applyStimulus(1'b1, 11'd1025, 1'b1, 32'd0);
        checkOutput("t3 err", 32'(err), 32'd1);
        checkOutput("t3 err cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("t3 err s_ready", 32'(s_ready), 32'd0);
        applyStimulus(1'b0, 11'd0, 1'b1, 32'd0);
        checkOutput("t3 err sticky", 32'(err), 32'd1);
        checkOutput("t3 err no write", 32'(imem_we), 32'd0);

        $display("[TB] retry from ERR, then reset mid-load");
        applyStimulus(1'b1, 11'd4, 1'b0, 32'd0);
        checkOutput("t4 retry s_ready", 32'(s_ready), 32'd1);
        checkOutput("t4 retry err", 32'(err), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 11'd0, 1'b1, 32'hDEAD_0000 + 32'(i));
            checkOutput("t4 partial addr", 32'(imem_addr), 32'(i));
        end
        rst_n = 1'b0;
        applyStimulus(1'b1, 11'd4, 1'b1, 32'h1234_5678);
        checkResetValues("t4 reset");
        rst_n = 1'b1;
        applyStimulus(1'b1, 11'd4, 1'b1, prog[0]);
        checkOutput("t4 reload s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 11'd0, 1'b1, prog[i]);
            checkOutput("t4 reload addr", 32'(imem_addr), 32'(i));
            checkOutput("t4 reload wdata", imem_wdata, prog[i]);
        end
        holdPhase("t4", 1'b0);

        $display("[TB] full-depth load of 1024 words");
        applyStimulus(1'b1, 11'd1024, 1'b1, 32'd0);
        checkOutput("full s_ready", 32'(s_ready), 32'd1);
        nextAddr = 0;
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(1'b0, 11'd0, 1'b1, 32'h5000_0000 + 32'(i));
            if (imem_we !== 1'b1 || 32'(imem_addr) != 32'(i)) nextAddr = -1;
        end
        checkOutput("full contiguous addrs", 32'(nextAddr), 32'd0);
        checkOutput("full last addr", 32'(imem_addr), 32'd1023);
        checkOutput("full last wdata", imem_wdata, 32'h5000_03FF);
        checkOutput("full s_ready after last", 32'(s_ready), 32'd0);
        holdPhase("full", 1'b1);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        $display("[TB] checksum match and mismatch");
        exp_sum = 32'd6;
        applyStimulus(1'b1, 11'd3, 1'b0, 32'd0);
        exp_sum = 32'd0;
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 11'd0, 1'b1, 32'(i));
        checkOutput("csum ok err", 32'(err), 32'd0);
        checkOutput("csum ok busy", 32'(busy), 32'd1);
        holdPhase("csum ok", 1'b0);
        exp_sum = 32'd7;
        applyStimulus(1'b1, 11'd3, 1'b0, 32'd0);
        exp_sum = 32'd0;
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 11'd0, 1'b1, 32'(i));
        checkOutput("csum bad err", 32'(err), 32'd1);
        checkOutput("csum bad cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        applyStimulus(1'b0, 11'd0, 1'b0, 32'd0);
        checkOutput("csum bad sticky", 32'(err), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
